// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// and loads the IF/ID register, with stall, redirect and fault handling.
module fetch_stage #(
  parameter int                   PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          MEM_DEPTH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_npc,
  output logic                if_id_valid,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count
);

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] npc;
    logic                valid;
  } if_id_t;

  localparam logic [PC_WIDTH:0] DEPTH =
    (PC_WIDTH + 1)'(MEM_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  if_id_t              if_id_q, if_id_d;
  logic                fault_q, fault_d;
  logic [31:0]         count_q, count_d;

  logic                in_range;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                do_fault;
  logic                do_branch;
  logic                do_stall;

  assign in_range  = {1'b0, pc_q} < DEPTH;
  assign pc_inc    = pc_q + PC_WIDTH'(1);

  // Fault beats redirect, redirect beats stall.
  assign do_fault  = fault_q;
  assign do_branch = !fault_q && branch_taken;
  assign do_stall  = !fault_q && !branch_taken
                     && stall;

  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    fault_d = fault_q;
    count_d = count_q;
    unique case (1'b1)
      do_fault: begin
        if_id_d = '0;
      end
      do_branch: begin
        pc_d    = branch_target;
        if_id_d = '0;
      end
      do_stall: begin
      end
      default: begin
        if (in_range) begin
          if_id_d.instr = imem_data;
          if_id_d.npc   = pc_inc;
          if_id_d.valid = 1'b1;
          pc_d          = pc_inc;
          count_d       = count_q + 32'd1;
        end else begin
          fault_d = 1'b1;
          if_id_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_npc   = if_id_q.npc;
  assign if_id_valid = if_id_q.valid;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];

  logic [31:0] m_pc, m_instr, m_npc, m_cnt;
  logic        m_valid, m_fault;

  fetch_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'd0),
    .MEM_DEPTH(128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_instr  (if_id_instr),
    .if_id_npc    (if_id_npc),
    .if_id_valid  (if_id_valid),
    .fetch_fault  (fetch_fault),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(
    input logic [31:0] a
  );
    if (a < 32'd256) return mem[a[7:0]];
    return 32'd0;
  endfunction

  assign imem_data = rd(imem_addr);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_instr = 0; m_npc = 0;
      m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (m_fault) begin
      m_instr = 0; m_npc = 0; m_valid = 0;
    end else if (branch_taken) begin
      m_pc = branch_target;
      m_instr = 0; m_npc = 0; m_valid = 0;
    end else if (stall) begin
    end else if (m_pc < 128) begin
      m_instr = rd(m_pc);
      m_npc   = m_pc + 1;
      m_valid = 1;
      m_pc    = m_pc + 1;
      m_cnt   = m_cnt + 1;
    end else begin
      m_fault = 1;
      m_instr = 0; m_npc = 0; m_valid = 0;
    end
  endtask

  task automatic cmp_all(input string t);
    chk({t, ".addr"},  imem_addr, m_pc);
    chk({t, ".instr"}, if_id_instr, m_instr);
    chk({t, ".npc"},   if_id_npc, m_npc);
    chk({t, ".valid"}, {31'd0, if_id_valid},
        {31'd0, m_valid});
    chk({t, ".fault"}, {31'd0, fetch_fault},
        {31'd0, m_fault});
    chk({t, ".cnt"},   fetch_count, m_cnt);
  endtask

  task automatic step(
    input logic        r,
    input logic        s,
    input logic        b,
    input logic [31:0] tgt,
    input string       t
  );
    rst = r; stall = s;
    branch_taken = b; branch_target = tgt;
    #1;
    model_edge();
    @(posedge clk);
    #1;
    cmp_all(t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = $urandom;
    mem[0] = 32'h002300AA;
    mem[1] = 32'h10654321;
    mem[2] = 32'h00100022;
    mem[3] = 32'h8C123456;
    rst = 1; stall = 0;
    branch_taken = 0; branch_target = 0;
    m_pc = 0; m_instr = 0; m_npc = 0;
    m_valid = 0; m_fault = 0; m_cnt = 0;
    @(negedge clk);

    step(1, 0, 0, 0, "rst0");
    step(1, 0, 0, 0, "rst1");
    chk("rst.valid", {31'd0, if_id_valid}, 0);
    chk("rst.addr", imem_addr, 32'd0);

    step(0, 0, 0, 0, "f0");
    chk("f0.instr", if_id_instr, 32'h002300AA);
    step(0, 0, 0, 0, "f1");
    chk("f1.npc", if_id_npc, 32'd2);

    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, "stall");
    chk("stall.addr", imem_addr, 32'd2);
    chk("stall.instr", if_id_instr,
        32'h10654321);
    chk("stall.cnt", fetch_count, 32'd2);

    step(0, 0, 0, 0, "f2");
    chk("f2.instr", if_id_instr, 32'h00100022);

    step(0, 0, 1, 6, "br");
    chk("br.addr", imem_addr, 32'd6);
    chk("br.valid", {31'd0, if_id_valid}, 0);
    step(0, 0, 0, 0, "br1");
    chk("br1.npc", if_id_npc, 32'd7);

    step(0, 1, 1, 0, "brst");
    chk("brst.addr", imem_addr, 32'd0);

    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, "run5");
    step(1, 1, 0, 0, "rstmid");
    chk("rstmid.cnt", fetch_count, 32'd0);
    step(0, 0, 0, 0, "run");

    step(0, 0, 1, 127, "br127");
    step(0, 0, 0, 0, "m127");
    chk("m127.npc", if_id_npc, 32'd128);
    step(0, 0, 0, 0, "oor");
    chk("oor.fault", {31'd0, fetch_fault}, 1);
    step(0, 0, 1, 0, "oorbr");
    chk("oorbr.addr", imem_addr, 32'd128);
    step(0, 1, 0, 0, "oorst");
    step(1, 0, 0, 0, "clr");
    chk("clr.fault", {31'd0, fetch_fault}, 0);

    for (int i = 0; i < 400; i++) begin
      logic        r, s, b;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 7) == 0);
      tgt = $urandom_range(0, 131);
      step(r, s, b, tgt, "rnd");
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
